// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared board package: CPU clock-controller state encodings and
// board-level constants used by the clock controller and button logic.
package cpu_clk_ctrl_pkg;

  // Depth of every asynchronous-input synchronizer on the board.
  localparam int unsigned SYNC_STAGES = 2;

  // Width of the free-running prescaler.
  localparam int unsigned PRESC_W = 32;

  // Width of the issued-cycle counter.
  localparam int unsigned CYCLE_CNT_W = 32;

  // Controller states; the encoding is also the value driven on mode_o.
  typedef enum logic [1:0] {
    ST_STEP   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } cpu_state_e;

  // True when bit idx of the prescaler goes 0->1 between cur and nxt.
  function automatic logic presc_bit_rise(input logic [PRESC_W-1:0] cur,
                                          input logic [PRESC_W-1:0] nxt,
                                          input logic [4:0]         idx);
    return ~cur[idx] & nxt[idx];
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Synchronizer plus debouncer for one mechanical push-button.
// Produces the accepted (debounced) level and a one-cycle pulse on
// each accepted press.
import cpu_clk_ctrl_pkg::*;

module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Bring the raw button into the clk domain before anything looks at it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
  end

  // Accept a new level only after it has disagreed with the current one
  // for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (btn_sync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = btn_sync;
        rise_d  = btn_sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: single-step from a debounced button,
// free-run at a fast or slow prescaled rate, halt on CPU request, and
// count every clock enable issued.
import cpu_clk_ctrl_pkg::*;

module cpu_clk_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned FAST_BIT        = 2,
  parameter int unsigned SLOW_BIT        = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run_sw_i,
  input  logic                   speed_sw_i,
  input  logic                   step_btn_i,
  input  logic                   halt_i,
  input  logic                   clr_cnt_i,
  output logic                   cpu_ce_o,
  output logic [CYCLE_CNT_W-1:0] cycle_cnt_o,
  output logic [1:0]             mode_o
);

  localparam logic [4:0] FAST_IDX = 5'(FAST_BIT);
  localparam logic [4:0] SLOW_IDX = 5'(SLOW_BIT);

  logic [SYNC_STAGES-1:0] run_sync_q;
  logic [SYNC_STAGES-1:0] speed_sync_q;
  logic                   run_on;
  logic                   slow_sel;

  logic                   step_level;
  logic                   step_rise;

  logic [PRESC_W-1:0]     prescaler_q, prescaler_d;
  logic [4:0]             tick_idx;
  logic                   run_tick;

  cpu_state_e             state_q, state_d;
  logic                   ce_req;
  logic                   cpu_ce_q, cpu_ce_d;
  logic [CYCLE_CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  assign run_on   = run_sync_q[SYNC_STAGES-1];
  assign slow_sel = speed_sync_q[SYNC_STAGES-1];

  // Synchronize the two slide switches into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_sync_q   <= '0;
      speed_sync_q <= '0;
    end else begin
      run_sync_q   <= {run_sync_q[SYNC_STAGES-2:0], run_sw_i};
      speed_sync_q <= {speed_sync_q[SYNC_STAGES-2:0], speed_sw_i};
    end
  end

  // Step button: synchronized, debounced, one pulse per accepted press.
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (step_btn_i),
    .level_o(step_level),
    .rise_o (step_rise)
  );

  // The run tick fires when the selected prescaler bit is about to rise.
  // Looking at the current and next prescaler value (rather than a delayed
  // copy of the bit) means a speed change never produces a spurious tick.
  always_comb begin
    prescaler_d = prescaler_q + 1'b1;
    tick_idx    = slow_sel ? SLOW_IDX : FAST_IDX;
    run_tick    = presc_bit_rise(prescaler_q, prescaler_d, tick_idx);
  end

  // Free-running prescaler; never cleared except by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prescaler_q <= '0;
    else     prescaler_q <= prescaler_d;
  end

  // Next-state logic; halt outranks run_sw while running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STEP:   if (run_on && !halt_i) state_d = ST_RUN;
      ST_RUN: begin
        if (halt_i)       state_d = ST_HALTED;
        else if (!run_on) state_d = ST_STEP;
      end
      ST_HALTED: if (!run_on) state_d = ST_STEP;
      default:   state_d = ST_STEP;
    endcase
  end

  // Enable source per state; the previous-cycle guard keeps two sources
  // from producing back-to-back enables across a STEP->RUN change.
  always_comb begin
    ce_req = 1'b0;
    unique case (state_q)
      ST_STEP: ce_req = step_rise & step_level;
      ST_RUN:  ce_req = run_tick & ~halt_i;
      default: ce_req = 1'b0;
    endcase
    cpu_ce_d = ce_req & ~cpu_ce_q;
  end

  // Clear wins over a simultaneous increment; the counter wraps naturally.
  always_comb begin
    if (clr_cnt_i) cycle_cnt_d = '0;
    else           cycle_cnt_d = cycle_cnt_q + {{(CYCLE_CNT_W-1){1'b0}}, cpu_ce_q};
  end

  // State, enable and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_STEP;
      cpu_ce_q    <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cpu_ce_q    <= cpu_ce_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cpu_ce_o    = cpu_ce_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign mode_o      = state_q;

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of stable clk cycles (10 ms at 100 MHz) before a button level is accepted.
REQ-002 Parameter FAST_BIT, default 2, prescaler bit used for fast run rate.
REQ-003 Parameter SLOW_BIT, default 25, prescaler bit used for slow run rate.
REQ-004 clk  input  1  system clock, 100 MHz; sole clock of the block.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 run_sw  input  1  asynchronous switch; 1 = free-run, 0 = single-step.
REQ-007 speed_sw  input  1  asynchronous switch; 1 = slow rate (SLOW_BIT), 0 = fast rate (FAST_BIT).
REQ-008 step_btn  input  1  asynchronous, bouncing push-button; each accepted press = one CPU cycle in step mode.
REQ-009 halt  input  1  synchronous to clk, from CPU; 1 = CPU requests stop.
REQ-010 clr_cnt  input  1  synchronous, 1 = clear cycle counter.
REQ-011 cpu_ce  output  1  CPU clock enable, one-clk-wide pulses.
REQ-012 cycle_cnt  output  32  number of cpu_ce pulses issued.
REQ-013 mode  output  2  current state: 00 STEP, 01 RUN, 10 HALTED.

Function
REQ-014 run_sw, speed_sw and step_btn SHALL each pass through a 2-flop synchronizer before any use.
REQ-015 Debounced step level SHALL change only after the synchronized button differs from it for DEBOUNCE_CYCLES consecutive clk cycles; any agreeing cycle SHALL restart the count at 0.
REQ-016 A step press event SHALL be a one-cycle pulse on the 0->1 transition of the debounced level; release SHALL generate no event.
REQ-017 A 32-bit free-running prescaler SHALL increment every clk cycle and wrap 0xFFFFFFFF -> 0.
REQ-018 Run tick SHALL be a one-cycle pulse when the selected prescaler bit goes 0->1 (period 2^(bit+1) clk: 8 fast, 2^26 slow).
REQ-019 speed_sw change SHALL NOT reset the prescaler; the next tick follows the new bit's next rising edge.
REQ-020 FSM states STEP, RUN, HALTED; STEP -> RUN when run_sw synced = 1 and halt = 0; RUN -> STEP when run_sw synced = 0; RUN -> HALTED when halt = 1; HALTED -> STEP when run_sw synced = 0; halt has priority over run_sw in RUN.
REQ-021 In STEP, cpu_ce SHALL equal the step press event, registered (1 clk after the debounced edge).
REQ-022 In RUN, cpu_ce SHALL equal the run tick, registered; a tick coinciding with halt = 1 SHALL be suppressed.
REQ-023 In HALTED, cpu_ce SHALL be 0; step presses are discarded.
REQ-024 cpu_ce SHALL never be high on two consecutive clk cycles.
REQ-025 cycle_cnt SHALL increment by 1 in the cycle after each cpu_ce pulse and wrap 0xFFFFFFFF -> 0.
REQ-026 clr_cnt = 1 SHALL set cycle_cnt to 0 next cycle, overriding a simultaneous increment.
REQ-027 mode SHALL be registered and reflect the FSM state.

Reset
REQ-028 rst SHALL asynchronously force: state STEP, mode 00, cpu_ce 0, cycle_cnt 0, prescaler 0, debounce counter 0, debounced level 0, all synchronizer flops 0.
REQ-029 A button held through reset release SHALL produce exactly one press event, after DEBOUNCE_CYCLES.
REQ-030 rst asserted mid-run SHALL drop cpu_ce within the same cycle (async), with no partial pulse after release.

Structure
REQ-031 State encodings (STEP, RUN, HALTED) SHALL live in the shared board package alongside board-level constants.
REQ-032 Synchronizer plus debouncer SHALL be a sub-module btn_debounce (parameter DEBOUNCE_CYCLES; outputs level and rise pulse), reusable for other board buttons.
REQ-033 Prescaler, FSM, enable generation and counter SHALL reside in cpu_clk_ctrl.

Verification (DEBOUNCE_CYCLES = 4)
REQ-034 Step: run_sw=0, step_btn bounces 1/0/1 then holds 1 for 10 cycles -> exactly one cpu_ce, cycle_cnt = 1, mode 00.
REQ-035 Fast run: run_sw=1, speed_sw=0 for 80 cycles -> cpu_ce every 8 cycles (~10 pulses), never adjacent, mode 01.
REQ-036 Halt: in RUN assert halt on a tick cycle -> that pulse suppressed, mode 10, no cpu_ce despite step presses; run_sw=0 -> mode 00.
REQ-037 Counter: preload cycle_cnt to 0xFFFFFFFF via 2^32-pulse-free force, one pulse -> 0; clr_cnt with simultaneous pulse -> 0.
REQ-038 Reset: assert rst mid-RUN -> cpu_ce, cycle_cnt, mode 0 immediately; held button after release -> one pulse after 4 + sync cycles.
